// File: rtl/writeback_stage.sv
// Writeback stage: two-entry result buffer between MEM and the register file.
// Write data and the effective write enable are resolved when an entry is
// accepted, so the pop side only moves stored values into the output register.
//
// Handshake: a transfer happens at a rising edge where in_valid && in_ready.
// in_ready comes from a register that tracks free space, gated only by reset.
// It has no combinational path from flush or wb_hold, so a pop in the same
// cycle does not let a third entry in. That entry waits one cycle.
module writeback_stage #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_regwrite,
  input  logic [4:0]      in_rd,
  input  logic [1:0]      in_wbsel,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_alu_result,
  input  logic [XLEN-1:0] in_mem_data,
  input  logic [XLEN-1:0] in_pc,
  input  logic            flush,
  input  logic            wb_hold,
  output logic            RegWrite,
  output logic [4:0]      RD,
  output logic [XLEN-1:0] WriteData,
  output logic [31:0]     commit_count
);

  // Write-source select encoding
  localparam logic [1:0] WB_ALU  = 2'b00;
  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  // Buffer storage, indexed by 1-bit head/tail pointers
  logic [1:0]      r_ent_we;
  logic [4:0]      r_ent_rd   [2];
  logic [XLEN-1:0] r_ent_data [2];
  logic            r_head;
  logic            r_tail;
  logic [1:0]      r_count;
  logic            r_space;

  logic            r_regwrite;
  logic [4:0]      r_rd;
  logic [XLEN-1:0] r_wdata;
  logic [31:0]     r_commit_count;

  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_next_count;
  logic [XLEN-1:0] w_load_ext;
  logic [XLEN-1:0] w_wdata;
  logic            w_we;

  assign in_ready     = !reset && r_space;
  assign RegWrite     = r_regwrite;
  assign RD           = r_rd;
  assign WriteData    = r_wdata;
  assign commit_count = r_commit_count;

  // Flush drops a concurrent offer; hold or flush blocks the pop
  assign w_push = in_valid && in_ready && !flush;
  assign w_pop  = !wb_hold && !flush && (r_count != 2'd0);

  // Load data extension; always taken from the low-order bits
  always_comb begin
    w_load_ext = in_mem_data;
    case (in_funct3)
      3'b000:  w_load_ext = {{(XLEN-8){in_mem_data[7]}},   in_mem_data[7:0]};
      3'b001:  w_load_ext = {{(XLEN-16){in_mem_data[15]}}, in_mem_data[15:0]};
      3'b010:  w_load_ext = {{(XLEN-32){in_mem_data[31]}}, in_mem_data[31:0]};
      3'b100:  w_load_ext = {{(XLEN-8){1'b0}},  in_mem_data[7:0]};
      3'b101:  w_load_ext = {{(XLEN-16){1'b0}}, in_mem_data[15:0]};
      3'b110:  w_load_ext = {{(XLEN-32){1'b0}}, in_mem_data[31:0]};
      default: w_load_ext = in_mem_data;
    endcase
  end

  // Select the value to store, and the effective write enable (x0 and "none" never write)
  always_comb begin
    w_wdata = '0;
    case (in_wbsel)
      WB_ALU:  w_wdata = in_alu_result;
      WB_LOAD: w_wdata = w_load_ext;
      WB_PC4:  w_wdata = in_pc + XLEN'(4);
      default: w_wdata = '0;
    endcase
    w_we = in_regwrite && (in_rd != 5'd0) && (in_wbsel != 2'b11);
  end

  // Occupancy after this edge's push/pop
  always_comb begin
    w_next_count = r_count;
    case ({w_push, w_pop})
      2'b10:   w_next_count = r_count + 2'd1;
      2'b01:   w_next_count = r_count - 2'd1;
      default: w_next_count = r_count;
    endcase
  end

  // Pointer and occupancy bookkeeping; flush and reset both empty the buffer
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
      r_space <= 1'b1;
    end else begin
      if (w_push) r_tail <= ~r_tail;
      if (w_pop)  r_head <= ~r_head;
      r_count <= w_next_count;
      r_space <= (w_next_count < 2'd2);
    end
  end

  // Entry payload capture; contents are only meaningful while counted as occupied
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ent_we <= 2'b00;
    end else if (w_push) begin
      r_ent_we[r_tail]   <= w_we;
      r_ent_rd[r_tail]   <= in_rd;
      r_ent_data[r_tail] <= w_wdata;
    end
  end

  // Output register and commit counter; RD/WriteData hold when nothing is popped
  always_ff @(posedge clk) begin
    if (reset) begin
      r_regwrite     <= 1'b0;
      r_rd           <= 5'd0;
      r_wdata        <= '0;
      r_commit_count <= 32'd0;
    end else if (w_pop) begin
      r_regwrite <= r_ent_we[r_head];
      r_rd       <= r_ent_rd[r_head];
      r_wdata    <= r_ent_data[r_head];
      if (r_ent_we[r_head]) r_commit_count <= r_commit_count + 32'd1;
    end else begin
      r_regwrite <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios with constant expectations,
// then randomized traffic against a queue-based reference model.
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, in_regwrite, flush, wb_hold;
  logic [4:0]  in_rd;
  logic [1:0]  in_wbsel;
  logic [2:0]  in_funct3;
  logic [63:0] in_alu_result, in_mem_data, in_pc;
  logic        RegWrite;
  logic [4:0]  RD;
  logic [63:0] WriteData;
  logic [31:0] commit_count;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: pending entries {we, rd, data} plus the visible outputs
  logic [69:0] exp_q[$];
  logic        m_rw;
  logic [4:0]  m_rd;
  logic [63:0] m_wd;
  logic [31:0] m_cnt;

  writeback_stage #(.XLEN(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_rd(in_rd), .in_wbsel(in_wbsel),
    .in_funct3(in_funct3), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_pc(in_pc), .flush(flush),
    .wb_hold(wb_hold), .RegWrite(RegWrite), .RD(RD),
    .WriteData(WriteData), .commit_count(commit_count)
  );

  // Clock
  always #5 clk = ~clk;

  function automatic logic [63:0] load_value(input logic [2:0] f3, input logic [63:0] m);
    case (f3)
      3'd0:    return 64'($signed(m[7:0]));
      3'd1:    return 64'($signed(m[15:0]));
      3'd2:    return 64'($signed(m[31:0]));
      3'd4:    return 64'(m[7:0]);
      3'd5:    return 64'(m[15:0]);
      3'd6:    return 64'(m[31:0]);
      default: return m;
    endcase
  endfunction

  function automatic logic [69:0] make_entry();
    logic        we;
    logic [63:0] d;
    we = in_regwrite && (in_rd != 0) && (in_wbsel != 2'd3);
    case (in_wbsel)
      2'd0:    d = in_alu_result;
      2'd1:    d = load_value(in_funct3, in_mem_data);
      2'd2:    d = in_pc + 64'd4;
      default: d = 64'd0;
    endcase
    return {we, in_rd, d};
  endfunction

  // Driver: advance one clock with the current inputs, updating the model for that edge.
  // Called at a falling edge; returns at the next falling edge.
  task automatic step();
    logic        acc;
    logic [69:0] e;
    if (reset) begin
      exp_q.delete();
      m_rw = 1'b0; m_rd = 5'd0; m_wd = 64'd0; m_cnt = 32'd0;
    end else if (flush) begin
      exp_q.delete();
      m_rw = 1'b0;
    end else begin
      acc = in_valid && (exp_q.size() < 2);
      if (!wb_hold && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_rw = e[69]; m_rd = e[68:64]; m_wd = e[63:0];
        if (m_rw) m_cnt = m_cnt + 32'd1;
      end else begin
        m_rw = 1'b0;
      end
      if (acc) exp_q.push_back(make_entry());
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    in_valid = 0; in_regwrite = 0; in_rd = 0; in_wbsel = 0; in_funct3 = 0;
    in_alu_result = 0; in_mem_data = 0; in_pc = 0; flush = 0; wb_hold = 0;
  endtask

  task automatic set_entry(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                           input logic [2:0] f3, input logic [63:0] alu,
                           input logic [63:0] mem, input logic [63:0] pc);
    in_valid = 1; in_regwrite = rw; in_rd = rd; in_wbsel = sel; in_funct3 = f3;
    in_alu_result = alu; in_mem_data = mem; in_pc = pc;
  endtask

  // Offer one entry for a single edge, then withdraw it
  task automatic offer(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [63:0] alu,
                       input logic [63:0] mem, input logic [63:0] pc);
    set_entry(rw, rd, sel, f3, alu, mem, pc);
    step();
    in_valid = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; in_valid = 1;
    step(); step();
    n_checks++;
    if ({in_ready, RegWrite, RD, WriteData, commit_count} !== 103'd0)
      $display("FAIL reset_state: got rdy=%0b rw=%0b rd=%0d wd=%h cnt=%0d, want all zero",
               in_ready, RegWrite, RD, WriteData, commit_count);
    else n_pass++;
    reset = 0; in_valid = 0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_reset: got %0b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_alu();
    offer(1, 5'd5, 2'd0, 3'd0, 64'h1234, 64'd0, 64'd0);
    n_checks++;
    if (RegWrite !== 1'b0) $display("FAIL alu_latency: got rw=%0b want 0 one edge after accept", RegWrite);
    else n_pass++;
    step();
    n_checks++;
    if (RegWrite !== 1'b1 || RD !== 5'd5 || WriteData !== 64'h1234 || commit_count !== 32'd1)
      $display("FAIL alu_commit: got rw=%0b rd=%0d wd=%h cnt=%0d, want rw=1 rd=5 wd=1234 cnt=1",
               RegWrite, RD, WriteData, commit_count);
    else n_pass++;
    step();
    n_checks++;
    if (RegWrite !== 1'b0 || RD !== 5'd5 || WriteData !== 64'h1234)
      $display("FAIL alu_hold_outputs: got rw=%0b rd=%0d wd=%h, want rw=0 rd=5 wd=1234",
               RegWrite, RD, WriteData);
    else n_pass++;
  endtask

  task automatic test_load();
    offer(1, 5'd10, 2'd1, 3'd0, 64'd0, 64'h80, 64'd0);
    step();
    n_checks++;
    if (WriteData !== 64'hFFFF_FFFF_FFFF_FF80 || commit_count !== 32'd2)
      $display("FAIL load_lb: got wd=%h cnt=%0d want ffffffffffffff80 cnt=2", WriteData, commit_count);
    else n_pass++;
    offer(1, 5'd11, 2'd1, 3'd4, 64'd0, 64'h80, 64'd0);
    step();
    n_checks++;
    if (WriteData !== 64'h80 || RD !== 5'd11)
      $display("FAIL load_lbu: got wd=%h rd=%0d want 80 rd=11", WriteData, RD);
    else n_pass++;
    offer(1, 5'd12, 2'd1, 3'd6, 64'd0, 64'h1234_5678_FFFF_FFFF, 64'd0);
    step();
    n_checks++;
    if (WriteData !== 64'h0000_0000_FFFF_FFFF || commit_count !== 32'd4)
      $display("FAIL load_lwu: got wd=%h cnt=%0d want 00000000ffffffff cnt=4", WriteData, commit_count);
    else n_pass++;
  endtask

  task automatic test_suppress();
    offer(1, 5'd0, 2'd0, 3'd0, 64'hDEAD, 64'd0, 64'd0);
    step();
    n_checks++;
    if (RegWrite !== 1'b0 || commit_count !== 32'd4)
      $display("FAIL rd0_suppress: got rw=%0b cnt=%0d want rw=0 cnt=4", RegWrite, commit_count);
    else n_pass++;
    offer(1, 5'd7, 2'd3, 3'd0, 64'hBEEF, 64'd0, 64'd0);
    step();
    n_checks++;
    if (RegWrite !== 1'b0 || commit_count !== 32'd4)
      $display("FAIL wbsel_none_suppress: got rw=%0b cnt=%0d want rw=0 cnt=4", RegWrite, commit_count);
    else n_pass++;
    offer(1, 5'd3, 2'd2, 3'd0, 64'd0, 64'd0, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    n_checks++;
    if (RegWrite !== 1'b1 || RD !== 5'd3 || WriteData !== 64'd0 || commit_count !== 32'd5)
      $display("FAIL pc4_wrap: got rw=%0b rd=%0d wd=%h cnt=%0d want rw=1 rd=3 wd=0 cnt=5",
               RegWrite, RD, WriteData, commit_count);
    else n_pass++;
  endtask

  task automatic test_hold();
    wb_hold = 1;
    set_entry(1, 5'd1, 2'd0, 3'd0, 64'hA, 64'd0, 64'd0);
    step();
    set_entry(1, 5'd2, 2'd0, 3'd0, 64'hB, 64'd0, 64'd0);
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL hold_second_ready: got %0b want 1", in_ready);
    else n_pass++;
    step();
    set_entry(1, 5'd3, 2'd0, 3'd0, 64'hC, 64'd0, 64'd0);
    n_checks++;
    if (in_ready !== 1'b0 || RegWrite !== 1'b0)
      $display("FAIL hold_full: got rdy=%0b rw=%0b want rdy=0 rw=0", in_ready, RegWrite);
    else n_pass++;
    step();
    wb_hold = 0;
    step();
    n_checks++;
    if (RegWrite !== 1'b1 || RD !== 5'd1 || WriteData !== 64'hA || in_ready !== 1'b1)
      $display("FAIL hold_release_first: got rw=%0b rd=%0d wd=%h rdy=%0b want rw=1 rd=1 wd=a rdy=1",
               RegWrite, RD, WriteData, in_ready);
    else n_pass++;
    step();
    in_valid = 0;
    n_checks++;
    if (RegWrite !== 1'b1 || RD !== 5'd2 || WriteData !== 64'hB)
      $display("FAIL hold_release_second: got rw=%0b rd=%0d wd=%h want rw=1 rd=2 wd=b",
               RegWrite, RD, WriteData);
    else n_pass++;
    step();
    n_checks++;
    if (RegWrite !== 1'b1 || RD !== 5'd3 || WriteData !== 64'hC || commit_count !== 32'd8)
      $display("FAIL hold_third: got rw=%0b rd=%0d wd=%h cnt=%0d want rw=1 rd=3 wd=c cnt=8",
               RegWrite, RD, WriteData, commit_count);
    else n_pass++;
    step();
    n_checks++;
    if (RegWrite !== 1'b0) $display("FAIL hold_drain_idle: got rw=%0b want 0", RegWrite);
    else n_pass++;
  endtask

  task automatic test_flush();
    wb_hold = 1;
    set_entry(1, 5'd4, 2'd0, 3'd0, 64'h44, 64'd0, 64'd0);
    step();
    set_entry(1, 5'd6, 2'd0, 3'd0, 64'h66, 64'd0, 64'd0);
    step();
    set_entry(1, 5'd8, 2'd0, 3'd0, 64'h88, 64'd0, 64'd0);
    flush = 1;
    step();
    n_checks++;
    if (in_ready !== 1'b1 || RegWrite !== 1'b0)
      $display("FAIL flush_ready: got rdy=%0b rw=%0b want rdy=1 rw=0", in_ready, RegWrite);
    else n_pass++;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      step();
      n_checks++;
      if (RegWrite !== 1'b0 || commit_count !== 32'd8)
        $display("FAIL flush_no_commit: cycle %0d got rw=%0b cnt=%0d want rw=0 cnt=8",
                 i, RegWrite, commit_count);
      else n_pass++;
    end
  endtask

  task automatic test_reset_midstream();
    wb_hold = 1;
    set_entry(1, 5'd13, 2'd0, 3'd0, 64'h1313, 64'd0, 64'd0);
    step();
    set_entry(1, 5'd14, 2'd0, 3'd0, 64'h1414, 64'd0, 64'd0);
    step();
    in_valid = 0; wb_hold = 0;
    step();
    reset = 1; in_valid = 1;
    step();
    n_checks++;
    if ({in_ready, RegWrite, RD, WriteData, commit_count} !== 103'd0)
      $display("FAIL reset_midstream: got rdy=%0b rw=%0b rd=%0d wd=%h cnt=%0d, want all zero",
               in_ready, RegWrite, RD, WriteData, commit_count);
    else n_pass++;
    reset = 0; in_valid = 0;
    step();
    n_checks++;
    if (RegWrite !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL reset_discards: got rw=%0b rdy=%0b want rw=0 rdy=1", RegWrite, in_ready);
    else n_pass++;
  endtask

  task automatic test_wrap();
    idle_inputs();
    force dut.r_commit_count = 32'hFFFF_FFFE;
    #1;
    release dut.r_commit_count;
    m_cnt = 32'hFFFF_FFFE;
    set_entry(1, 5'd9, 2'd0, 3'd0, 64'h1, 64'd0, 64'd0);
    step();
    set_entry(1, 5'd9, 2'd0, 3'd0, 64'h2, 64'd0, 64'd0);
    step();
    in_valid = 0;
    n_checks++;
    if (commit_count !== 32'hFFFF_FFFF || RegWrite !== 1'b1)
      $display("FAIL wrap_max: got cnt=%h rw=%0b want ffffffff rw=1", commit_count, RegWrite);
    else n_pass++;
    step();
    n_checks++;
    if (commit_count !== 32'd0 || RegWrite !== 1'b1 || WriteData !== 64'h2)
      $display("FAIL wrap_zero: got cnt=%h rw=%0b wd=%h want 0 rw=1 wd=2", commit_count, RegWrite, WriteData);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [102:0] obs, exp;
    idle_inputs();
    for (int i = 0; i < 400; i++) begin
      reset         = ($urandom_range(0, 79) == 0);
      flush         = ($urandom_range(0, 24) == 0);
      wb_hold       = ($urandom_range(0, 3) == 0);
      in_valid      = ($urandom_range(0, 2) != 0);
      in_regwrite   = ($urandom_range(0, 5) != 0);
      in_rd         = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      in_wbsel      = 2'($urandom_range(0, 3));
      in_funct3     = 3'($urandom_range(0, 7));
      in_alu_result = {$urandom, $urandom};
      in_mem_data   = {$urandom, $urandom};
      in_pc         = ($urandom_range(0, 9) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
      step();
      obs = {in_ready, RegWrite, RD, WriteData, commit_count};
      exp = {(!reset && exp_q.size() < 2), m_rw, m_rd, m_wd, m_cnt};
      n_checks++;
      if (obs !== exp)
        $display("FAIL random_cycle %0d: got rdy=%0b rw=%0b rd=%0d wd=%h cnt=%0d, want rdy=%0b rw=%0b rd=%0d wd=%h cnt=%0d",
                 i, obs[102], obs[101], obs[100:96], obs[95:32], obs[31:0],
                 exp[102], exp[101], exp[100:96], exp[95:32], exp[31:0]);
      else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    m_rw = 0; m_rd = 0; m_wd = 0; m_cnt = 0;
    @(negedge clk);
    test_reset();
    test_alu();
    test_load();
    test_suppress();
    test_hold();
    test_flush();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
